loop_ro_decoder: RTL and testbench

- Decodes the loop operand field of a LOOP instruction against the 8-entry loop read-only table of the current program.
- Produces the iteration count, jump amount, loop name and flags consumed by the control unit's loop-stack FSM.
- Decode is combinational so it completes in the DECODE cycle.
- Adds a registered copy of the last decode and a sticky table-consistency error flag.

---
 rtl/loop_ro_decoder_if.sv | 33 +++
 rtl/loop_ro_decoder.sv | 76 +++++++
 tb/tb_loop_ro_decoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/loop_ro_decoder_if.sv
// rtl/loop_ro_decoder_if.sv - decode-side signal bundle for the loop read-only table decoder
interface loop_ro_decoder_if #(
   parameter int LOG_LOOP_CNT = 3,
   parameter int ITER_W       = 18,
   parameter int JUMP_W       = 6,
   parameter int ENTRY_W      = 24
);
   localparam int ENTRIES = 1 << LOG_LOOP_CNT;
   localparam int INSTR_W = 2 + LOG_LOOP_CNT + ITER_W + JUMP_W;

   logic [LOG_LOOP_CNT-1:0]    addr;
   logic [ENTRIES*ENTRY_W-1:0] in;
   logic                       independent;
   logic                       new_loop;
   logic                       dec_en;
   logic                       err_clr;
   logic [INSTR_W-1:0]         loop_instr;
   logic [INSTR_W-1:0]         loop_instr_q;
   logic                       loop_valid_q;
   logic                       table_error;

   // Control unit side: presents the instruction fields and table.
   modport master (
      output addr, in, independent, new_loop, dec_en, err_clr,
      input  loop_instr, loop_instr_q, loop_valid_q, table_error
   );

   // Decoder side.
   modport slave (
      input  addr, in, independent, new_loop, dec_en, err_clr,
      output loop_instr, loop_instr_q, loop_valid_q, table_error
   );
endinterface

// File: rtl/loop_ro_decoder.sv
// rtl/loop_ro_decoder.sv - LOOP operand decoder with registered copy; optional table check via LOOPMUX_TABLE_CHECK_EN
module loop_ro_decoder #(
   parameter int LOG_LOOP_CNT = 3,
   parameter int ITER_W       = 18,
   parameter int JUMP_W       = 6,
   parameter int ENTRY_W      = 24
) (
   input logic                clk,
   input logic                reset,
   loop_ro_decoder_if.slave   bus
);
   logic [ENTRY_W-1:0] entry;
   logic [ITER_W-1:0]  iter_count;
   logic [JUMP_W-1:0]  jump_amount;

   // Full 8-way table select with constant slices only.
   always_comb begin
      entry = '0;
      case (bus.addr)
         3'd0:    entry = bus.in[0*ENTRY_W +: ENTRY_W];
         3'd1:    entry = bus.in[1*ENTRY_W +: ENTRY_W];
         3'd2:    entry = bus.in[2*ENTRY_W +: ENTRY_W];
         3'd3:    entry = bus.in[3*ENTRY_W +: ENTRY_W];
         3'd4:    entry = bus.in[4*ENTRY_W +: ENTRY_W];
         3'd5:    entry = bus.in[5*ENTRY_W +: ENTRY_W];
         3'd6:    entry = bus.in[6*ENTRY_W +: ENTRY_W];
         3'd7:    entry = bus.in[7*ENTRY_W +: ENTRY_W];
         default: entry = '0;
      endcase
   end

   assign iter_count  = entry[ITER_W-1:0];
   assign jump_amount = entry[ENTRY_W-1:ITER_W];

   // Independence only has meaning when a loop is being opened.
   assign bus.loop_instr = {bus.new_loop,
                            bus.independent & bus.new_loop,
                            bus.addr,
                            iter_count,
                            jump_amount};

   // Capture the decode whenever a LOOP instruction sits in DECODE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.loop_instr_q <= '0;
         bus.loop_valid_q <= 1'b0;
      end else begin
         bus.loop_valid_q <= bus.dec_en;
         if (bus.dec_en)
            bus.loop_instr_q <= bus.loop_instr;
      end
   end

`ifdef LOOPMUX_TABLE_CHECK_EN
   logic new_error;

   // A zero-trip start or a zero back-jump end means the table is inconsistent.
   assign new_error = bus.dec_en &
                      (bus.new_loop ? (iter_count == '0) : (jump_amount == '0));

   // Sticky flag; a fresh error beats a concurrent clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         bus.table_error <= 1'b0;
      else if (new_error)
         bus.table_error <= 1'b1;
      else if (bus.err_clr)
         bus.table_error <= 1'b0;
   end
`else
   logic unused_err_clr;

   assign unused_err_clr  = bus.err_clr;
   assign bus.table_error = 1'b0;
`endif
endmodule

// File: tb/tb_loop_ro_decoder.sv
// tb/tb_loop_ro_decoder.sv - randomized self-checking bench for loop_ro_decoder
module tb_loop_ro_decoder;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   // Reference table held as separate fields.
   logic [17:0] tbl_iter [8];
   logic [5:0]  tbl_jump [8];

   // Reference registered state.
   logic [28:0] exp_q;
   logic        exp_valid;
   logic        exp_err;

   loop_ro_decoder_if bus_if ();

   loop_ro_decoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic load_table();
      logic [191:0] v;
      v = '0;
      for (int k = 0; k < 8; k++)
         v[k*24 +: 24] = {tbl_jump[k], tbl_iter[k]};
      bus_if.in = v;
   endtask

   function automatic logic [28:0] model_decode(input logic [2:0] a, input logic nl, input logic ind);
      return {nl, ind && nl, a, tbl_iter[a], tbl_jump[a]};
   endfunction

   // One decode cycle: drive at negedge, check comb, clock, check registered.
   task automatic run_cycle(input string tag, input logic [2:0] a, input logic nl,
                            input logic ind, input logic de, input logic ec);
      logic bad;
      @(negedge clk);
      bus_if.addr        = a;
      bus_if.new_loop    = nl;
      bus_if.independent = ind;
      bus_if.dec_en      = de;
      bus_if.err_clr     = ec;
      #1;
      check({tag, "_comb"}, 32'(bus_if.loop_instr), 32'(model_decode(a, nl, ind)));
      @(posedge clk);
      exp_valid = de;
      if (de)
         exp_q = model_decode(a, nl, ind);
`ifdef LOOPMUX_TABLE_CHECK_EN
      bad = de && (nl ? (tbl_iter[a] == 0) : (tbl_jump[a] == 0));
      if (bad)
         exp_err = 1'b1;
      else if (ec)
         exp_err = 1'b0;
`else
      bad = 1'b0;
      exp_err = bad;
`endif
      #1;
      check({tag, "_q"},     32'(bus_if.loop_instr_q), 32'(exp_q));
      check({tag, "_valid"}, 32'(bus_if.loop_valid_q), 32'(exp_valid));
      check({tag, "_err"},   32'(bus_if.table_error),  32'(exp_err));
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b0;
      exp_q    = '0;
      exp_valid = 1'b0;
      exp_err  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tbl_iter[k] = 18'(k + 1);
         tbl_jump[k] = 6'(k + 1);
      end
      load_table();
      bus_if.addr        = '0;
      bus_if.new_loop    = 1'b0;
      bus_if.independent = 1'b0;
      bus_if.dec_en      = 1'b1;
      bus_if.err_clr     = 1'b0;

      // Reset state, with dec_en high to show nothing is captured.
      repeat (2) @(posedge clk);
      #1;
      check("rst_q",     32'(bus_if.loop_instr_q), 32'd0);
      check("rst_valid", 32'(bus_if.loop_valid_q), 32'd0);
      check("rst_err",   32'(bus_if.table_error),  32'd0);
      @(negedge clk);
      bus_if.dec_en = 1'b0;
      reset = 1'b1;

      // Start-loop decode.
      tbl_iter[2] = 18'd100;
      tbl_jump[2] = 6'd5;
      load_table();
      run_cycle("start", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      check("start_lit", 32'(bus_if.loop_instr_q), {3'b0, 1'b1, 1'b1, 3'd2, 18'd100, 6'd5});
      run_cycle("start_hold", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);

      // End-loop decode forces independence off.
      tbl_iter[7] = 18'd8;
      tbl_jump[7] = 6'd3;
      load_table();
      run_cycle("end", 3'd7, 1'b0, 1'b1, 1'b1, 1'b0);
      check("end_lit", 32'(bus_if.loop_instr_q), {3'b0, 1'b0, 1'b0, 3'd7, 18'd8, 6'd3});

      // Table change with no decode leaves the registered copy alone.
      tbl_iter[7] = 18'h3ffff;
      load_table();
      run_cycle("tblchg", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);

      // Address sweep with distinct entries; also both table ends.
      for (int k = 0; k < 8; k++) begin
         tbl_iter[k] = 18'(k * 1000);
         tbl_jump[k] = 6'(k + 1);
      end
      tbl_iter[0] = 18'd1;
      tbl_jump[7] = 6'h3f;
      load_table();
      for (int k = 0; k < 8; k++)
         run_cycle($sformatf("sweep%0d", k), 3'(k), 1'b0, 1'b0, 1'b1, 1'b0);

      // Zero-trip start loop, sticky over clean decodes, clear, clear-vs-error.
      tbl_iter[4] = 18'd0;
      tbl_jump[4] = 6'd9;
      tbl_iter[5] = 18'd50;
      load_table();
      run_cycle("zt_err",   3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      run_cycle("zt_stick", 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      run_cycle("zt_clr",   3'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      run_cycle("zt_err2",  3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      run_cycle("zt_race",  3'd4, 1'b1, 1'b0, 1'b1, 1'b1);
      run_cycle("zt_clr2",  3'd5, 1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized decodes against the model.
      for (int i = 0; i < 200; i++) begin
         if (i % 10 == 0) begin
            for (int k = 0; k < 8; k++) begin
               tbl_iter[k] = ($urandom_range(0, 5) == 0) ? 18'd0 : 18'($urandom);
               tbl_jump[k] = ($urandom_range(0, 5) == 0) ? 6'd0  : 6'($urandom);
            end
            load_table();
         end
         run_cycle($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 4) == 0));
      end

      // Mid-operation asynchronous reset with a nonzero capture.
      tbl_iter[1] = 18'd77;
      tbl_jump[1] = 6'd2;
      load_table();
      run_cycle("pre_rst", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_q",     32'(bus_if.loop_instr_q), 32'd0);
      check("arst_valid", 32'(bus_if.loop_valid_q), 32'd0);
      check("arst_err",   32'(bus_if.table_error),  32'd0);
      bus_if.dec_en = 1'b1;
      #1;
      check("arst_comb", 32'(bus_if.loop_instr), 32'(model_decode(3'd1, 1'b1, 1'b1)));
      @(posedge clk);
      #1;
      check("arst_nocap_q",     32'(bus_if.loop_instr_q), 32'd0);
      check("arst_nocap_valid", 32'(bus_if.loop_valid_q), 32'd0);
      @(negedge clk);
      bus_if.dec_en = 1'b0;
      reset = 1'b1;
      exp_q = '0;
      exp_valid = 1'b0;
      exp_err = 1'b0;
      run_cycle("post_rst", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
